mips_multicycle_ctrl: RTL and testbench

Moore/Mealy finite-state controller that sequences the multicycle MIPS datapath, one instruction at a time, over 4–7 clock cycles. It drives every datapath select and write enable. These include the 2-bit ALU source-B select: 00 Reg_B, 01 constant 4, 10 sign-extend, 11 shifted sign-extend. It sits beside the datapath, takes opcode/funct from the instruction register and `alu_zero` from the ALU, and returns to instruction fetch after each instruction.

---
 rtl/mips_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/writeback for
// one instruction at a time and drives every datapath select and enable.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_FETCH = 4'd1,
    S_FWAIT = 4'd2,
    S_DEC   = 4'd3,
    S_MADDR = 4'd4,
    S_MRD   = 4'd5,
    S_MRDW  = 4'd6,
    S_MWB   = 4'd7,
    S_MWR   = 4'd8,
    S_EXR   = 4'd9,
    S_WBR   = 4'd10,
    S_EXI   = 4'd11,
    S_WBI   = 4'd12,
    S_BR    = 4'd13,
    S_JMP   = 4'd14,
    S_ILL   = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  state_e state_q, state_d;
  logic   funct_legal;
  logic [2:0] funct_op;

  // Map R-type funct to an ALU operation and flag unsupported encodings.
  always_comb begin
    funct_legal = 1'b1;
    funct_op    = ALU_IDLE;
    unique case (funct)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_SLT:  funct_op = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  // Next-state selection; opcode/funct only matter in DECODE and MADDR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: state_d = S_DEC;
      S_DEC: begin
        if (opcode == OP_LW || opcode == OP_SW)      state_d = S_MADDR;
        else if (opcode == OP_R && funct_legal)      state_d = S_EXR;
        else if (opcode == OP_ADDI)                  state_d = S_EXI;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BR;
        else if (opcode == OP_J)                     state_d = S_JMP;
        else                                         state_d = S_ILL;
      end
      S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_MRDW;
      S_MRDW:  state_d = S_MWB;
      S_EXR:   state_d = S_WBR;
      S_EXI:   state_d = S_WBI;
      S_MWB, S_MWR, S_WBR, S_WBI, S_BR, S_JMP, S_ILL: state_d = S_FETCH;
      default: state_d = S_RST;
    endcase
  end

  // State register; async reset forces RST so all decoded outputs drop at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  // Moore output decode from the state register; BR pc_write is the one Mealy term.
  always_comb begin
    pc_write     = 1'b0;
    iord         = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = ALU_IDLE;
    pc_source    = 2'b00;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        pc_write  = 1'b1;
      end
      S_FWAIT: ir_write = 1'b1;
      S_DEC: begin
        alu_src_b    = 2'b11;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
      end
      S_MADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
      end
      S_MRD:  iord = 1'b1;
      S_MRDW: begin
        iord      = 1'b1;
        mdr_write = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXR: begin
        alu_src_a    = 1'b1;
        alu_op       = funct_op;
        aluout_write = 1'b1;
      end
      S_WBR: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_EXI: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
      end
      S_WBI: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = 2'b01;
        instr_done = 1'b1;
        pc_write   = ((opcode == OP_BEQ) && alu_zero) ||
                     ((opcode == OP_BNE) && !alu_zero);
      end
      S_JMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ILL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through its state sequence and checks state code and every output.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       pc_write, iord, mem_write, ir_write, mdr_write, aluout_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .pc_write(pc_write), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
    .aluout_write(aluout_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pcw iord mw irw mdrw aow rw rdst m2r sa sb[1:0] op[2:0] ps[1:0] done ill
  logic [18:0] obs;
  assign obs = {pc_write, iord, mem_write, ir_write, mdr_write, aluout_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};

  // Hand-written expected output vectors, one per state flavour.
  localparam logic [18:0] O_ZERO  = 19'b0_0_0_0_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [18:0] O_FETCH = 19'b1_0_0_0_0_0_0_0_0_0_01_001_00_0_0;
  localparam logic [18:0] O_FWAIT = 19'b0_0_0_1_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [18:0] O_DEC   = 19'b0_0_0_0_0_1_0_0_0_0_11_001_00_0_0;
  localparam logic [18:0] O_MADDR = 19'b0_0_0_0_0_1_0_0_0_1_10_001_00_0_0;
  localparam logic [18:0] O_MRD   = 19'b0_1_0_0_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [18:0] O_MRDW  = 19'b0_1_0_0_1_0_0_0_0_0_00_000_00_0_0;
  localparam logic [18:0] O_MWB   = 19'b0_0_0_0_0_0_1_0_1_0_00_000_00_1_0;
  localparam logic [18:0] O_MWR   = 19'b0_1_1_0_0_0_0_0_0_0_00_000_00_1_0;
  localparam logic [18:0] O_EXSUB = 19'b0_0_0_0_0_1_0_0_0_1_00_010_00_0_0;
  localparam logic [18:0] O_EXOR  = 19'b0_0_0_0_0_1_0_0_0_1_00_100_00_0_0;
  localparam logic [18:0] O_WBR   = 19'b0_0_0_0_0_0_1_1_0_0_00_000_00_1_0;
  localparam logic [18:0] O_EXI   = 19'b0_0_0_0_0_1_0_0_0_1_10_001_00_0_0;
  localparam logic [18:0] O_WBI   = 19'b0_0_0_0_0_0_1_0_0_0_00_000_00_1_0;
  localparam logic [18:0] O_BRT   = 19'b1_0_0_0_0_0_0_0_0_1_00_010_01_1_0;
  localparam logic [18:0] O_BRN   = 19'b0_0_0_0_0_0_0_0_0_1_00_010_01_1_0;
  localparam logic [18:0] O_JMP   = 19'b1_0_0_0_0_0_0_0_0_0_00_000_10_1_0;
  localparam logic [18:0] O_ILL   = 19'b0_0_0_0_0_0_0_0_0_0_00_000_00_1_1;

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic now_is(input string tag, input logic [3:0] st, input logic [18:0] ov);
    chk({tag, "_state"}, {15'd0, state}, {15'd0, st});
    chk({tag, "_outs"}, obs, ov);
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [18:0] ov);
    @(posedge clk);
    #1;
    now_is(tag, st, ov);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    opcode   = 6'b000000;
    funct    = 6'b000000;
    alu_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    now_is("reset", 4'd0, O_ZERO);

    // Release: first edge goes to FETCH.
    reset_n = 1'b1;
    step("rel_fetch", 4'd1, O_FETCH);

    // R-type sub: 1,2,3,9,10,1
    opcode = 6'b000000; funct = 6'b100010;
    step("sub_fwait", 4'd2, O_FWAIT);
    step("sub_dec",   4'd3, O_DEC);
    step("sub_exr",   4'd9, O_EXSUB);
    step("sub_wbr",   4'd10, O_WBR);
    step("sub_fetch", 4'd1, O_FETCH);

    // lw: 1,2,3,4,5,6,7,1
    opcode = 6'b100011; funct = 6'b000000;
    step("lw_fwait", 4'd2, O_FWAIT);
    step("lw_dec",   4'd3, O_DEC);
    step("lw_maddr", 4'd4, O_MADDR);
    step("lw_mrd",   4'd5, O_MRD);
    step("lw_mrdw",  4'd6, O_MRDW);
    step("lw_mwb",   4'd7, O_MWB);
    step("lw_fetch", 4'd1, O_FETCH);

    // sw: 1,2,3,4,8,1
    opcode = 6'b101011;
    step("sw_fwait", 4'd2, O_FWAIT);
    step("sw_dec",   4'd3, O_DEC);
    step("sw_maddr", 4'd4, O_MADDR);
    step("sw_mwr",   4'd8, O_MWR);
    step("sw_fetch", 4'd1, O_FETCH);

    // beq: taken when zero, and pc_write follows alu_zero within the cycle
    opcode = 6'b000100; alu_zero = 1'b1;
    step("beq_fwait", 4'd2, O_FWAIT);
    step("beq_dec",   4'd3, O_DEC);
    step("beq_br_z1", 4'd13, O_BRT);
    alu_zero = 1'b0;
    #1;
    now_is("beq_br_z0", 4'd13, O_BRN);
    step("beq_fetch", 4'd1, O_FETCH);

    // bne: inverse sense
    opcode = 6'b000101; alu_zero = 1'b0;
    step("bne_fwait", 4'd2, O_FWAIT);
    step("bne_dec",   4'd3, O_DEC);
    step("bne_br_z0", 4'd13, O_BRT);
    alu_zero = 1'b1;
    #1;
    now_is("bne_br_z1", 4'd13, O_BRN);
    step("bne_fetch", 4'd1, O_FETCH);
    alu_zero = 1'b0;

    // j
    opcode = 6'b000010;
    step("j_fwait", 4'd2, O_FWAIT);
    step("j_dec",   4'd3, O_DEC);
    step("j_jmp",   4'd14, O_JMP);
    step("j_fetch", 4'd1, O_FETCH);

    // illegal opcode
    opcode = 6'b111111;
    step("ilo_fwait", 4'd2, O_FWAIT);
    step("ilo_dec",   4'd3, O_DEC);
    step("ilo_ill",   4'd15, O_ILL);
    step("ilo_fetch", 4'd1, O_FETCH);

    // R-type with unsupported funct
    opcode = 6'b000000; funct = 6'b000000;
    step("ilf_fwait", 4'd2, O_FWAIT);
    step("ilf_dec",   4'd3, O_DEC);
    step("ilf_ill",   4'd15, O_ILL);
    step("ilf_fetch", 4'd1, O_FETCH);

    // R-type or
    funct = 6'b100101;
    step("or_fwait", 4'd2, O_FWAIT);
    step("or_dec",   4'd3, O_DEC);
    step("or_exr",   4'd9, O_EXOR);
    step("or_wbr",   4'd10, O_WBR);
    step("or_fetch", 4'd1, O_FETCH);

    // addi: 1,2,3,11,12,1
    opcode = 6'b001000;
    step("addi_fwait", 4'd2, O_FWAIT);
    step("addi_dec",   4'd3, O_DEC);
    step("addi_exi",   4'd11, O_EXI);
    step("addi_wbi",   4'd12, O_WBI);
    step("addi_fetch", 4'd1, O_FETCH);

    // lw interrupted by reset in MRDW, between clock edges
    opcode = 6'b100011;
    step("mid_fwait", 4'd2, O_FWAIT);
    step("mid_dec",   4'd3, O_DEC);
    step("mid_maddr", 4'd4, O_MADDR);
    step("mid_mrd",   4'd5, O_MRD);
    step("mid_mrdw",  4'd6, O_MRDW);
    #2;
    reset_n = 1'b0;
    #1;
    now_is("mid_rst", 4'd0, O_ZERO);
    step("mid_hold", 4'd0, O_ZERO);
    reset_n = 1'b1;
    step("mid_fetch", 4'd1, O_FETCH);
    step("mid_fwait2", 4'd2, O_FWAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
